// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad event queue: key code type,
// lowest-priority-bit selection and one-hot to code encoding.
package keypad_pkg;

  typedef logic [3:0] key_code_t;

  localparam int KEY_COUNT = 16;

  // Isolates the lowest-index set bit (two's-complement trick).
  function automatic logic [15:0] lowest_set(input logic [15:0] v);
    return v & (~v + 16'd1);
  endfunction

  function automatic key_code_t encode16(input logic [15:0] onehot);
    key_code_t c;
    c = '0;
    for (int i = 0; i < KEY_COUNT; i++) begin
      if (onehot[i]) c = c | key_code_t'(i);
    end
    return c;
  endfunction

endpackage

// File: rtl/keypad_fifo.sv
// Small event FIFO with registered head outputs; head reads 0 when empty.
// Handshake: an entry leaves when valid && pop; pop while valid is low is ignored.
module keypad_fifo
  import keypad_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       push,
  input  logic [3:0]                 data_in,
  input  logic                       pop,
  output logic                       valid,
  output logic [3:0]                 head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  key_code_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   rd_ptr_nxt;
  logic [CW-1:0]   count_nxt;
  logic            pop_eff;
  key_code_t       head_nxt;

  assign pop_eff    = pop & valid;
  assign rd_ptr_nxt = rd_ptr + AW'(pop_eff);
  assign count_nxt  = count + CW'(push) - CW'(pop_eff);

  // The next head may be the entry being written this very cycle.
  always_comb begin
    head_nxt = '0;
    if (count_nxt != '0) begin
      if (push && (rd_ptr_nxt == wr_ptr)) head_nxt = data_in;
      else                                head_nxt = mem[rd_ptr_nxt];
    end
  end

  always_ff @(posedge Clock) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      head   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      valid  <= (count_nxt != '0);
      head   <= head_nxt;
    end
  end

endmodule

// File: rtl/keypad_event_queue.sv
// Turns the debounced key bitmap into a queue of key-press codes.
// Optional auto-repeat is compiled in with KEYPAD_REPEAT_EN.
module keypad_event_queue
  import keypad_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int REPEAT_DELAY = 50000000,
  parameter int REPEAT_RATE  = 10000000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] keys,
  output logic        valid,
  output logic [3:0]  code,
  input  logic        ready,
  output logic        overflow,
  input  logic        clr_ovf
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [15:0]   prev;
  logic [15:0]   pending;
  logic [15:0]   rise;
  logic [15:0]   rep_bits;
  logic [15:0]   set_bits;
  logic [15:0]   grant;
  logic [CW-1:0] count;
  logic          pop;
  logic          can_accept;
  logic          push;
  logic          merge;

  assign pop        = valid & ready;
  assign can_accept = (count != CW'(DEPTH)) || pop;
  assign grant      = can_accept ? lowest_set(pending) : '0;
  assign push       = |grant;
  assign rise       = keys & ~prev;
  assign set_bits   = rise | rep_bits;
  assign merge      = |(set_bits & pending);

`ifdef KEYPAD_REPEAT_EN
  logic [31:0] rep_cnt;
  logic        rep_first;
  logic        hold;
  logic        rep_fire;

  // A single key held steady; any change or chord restarts the timer.
  assign hold     = (keys != '0) && (keys == prev) && ((keys & (keys - 16'd1)) == '0);
  assign rep_fire = hold && (rep_cnt == (rep_first ? 32'(REPEAT_DELAY - 1)
                                                   : 32'(REPEAT_RATE - 1)));
  assign rep_bits = rep_fire ? keys : '0;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (!hold) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (rep_fire) begin
      rep_cnt   <= '0;
      rep_first <= 1'b0;
    end else begin
      rep_cnt   <= rep_cnt + 32'd1;
    end
  end
`else
  assign rep_bits = '0;
`endif

  // prev resets to all ones so keys held across reset release are not events.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      prev     <= '1;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      prev    <= keys;
      pending <= (pending | set_bits) & ~grant;
      if (merge)        overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  keypad_fifo #(.DEPTH(DEPTH)) u_fifo (
    .Clock   (Clock),
    .Reset   (Reset),
    .push    (push),
    .data_in (encode16(grant)),
    .pop     (pop),
    .valid   (valid),
    .head    (code),
    .count   (count)
  );

endmodule

// File: tb/tb_keypad_event_queue.sv
// Self-checking bench for keypad_event_queue (default build, repeat disabled):
// directed scenarios followed by random key/ready traffic against a queue model.
module tb_keypad_event_queue;

  localparam int DEPTH = 4;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] keys;
  logic        ready;
  logic        clr_ovf;
  logic        valid;
  logic [3:0]  code;
  logic        overflow;

  keypad_event_queue #(.DEPTH(DEPTH), .REPEAT_DELAY(10), .REPEAT_RATE(4)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .keys     (keys),
    .valid    (valid),
    .code     (code),
    .ready    (ready),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: queued codes, previous bitmap, pending presses, flag.
  logic [3:0]  exp_q[$];
  logic [15:0] m_prev;
  logic [15:0] m_pend;
  logic        m_ovf;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_prev = '1;
    m_pend = '0;
    m_ovf  = 1'b0;
  endtask

  // One clock edge of the behaviour: pop, then serve the lowest pending key.
  task automatic model_edge();
    logic        do_pop;
    logic        accept;
    logic [15:0] rise;
    int          g;
    g      = -1;
    do_pop = (exp_q.size() != 0) && ready;
    accept = (exp_q.size() < DEPTH) || do_pop;
    if (accept) begin
      for (int i = 0; i < 16; i++) begin
        if (m_pend[i] && g < 0) g = i;
      end
    end
    rise = keys & ~m_prev;
    if ((rise & m_pend) != '0) m_ovf = 1'b1;
    else if (clr_ovf)          m_ovf = 1'b0;
    if (do_pop) void'(exp_q.pop_front());
    m_pend = m_pend | rise;
    if (g >= 0) begin
      exp_q.push_back(4'(g));
      m_pend[g] = 1'b0;
    end
    m_prev = keys;
  endtask

  task automatic compare_outputs();
    check("valid", 16'(valid), 16'(exp_q.size() != 0));
    check("code", 16'(code), (exp_q.size() != 0) ? 16'(exp_q[0]) : 16'd0);
    check("overflow", 16'(overflow), 16'(m_ovf));
  endtask

  task automatic step(input logic [15:0] k, input logic r, input logic c);
    keys    = k;
    ready   = r;
    clr_ovf = c;
    @(posedge Clock);
    if (Reset) model_edge();
    else       model_reset();
    #1;
    compare_outputs();
  endtask

  initial begin
    logic [15:0] k;
    int          sel;
    int          six[6];
    six = '{1, 3, 6, 9, 12, 14};

    keys = 16'h0004; ready = 1'b0; clr_ovf = 1'b0;
    model_reset();
    #12;
    compare_outputs();
    step(16'h0004, 1'b0, 1'b0);
    Reset = 1'b1;

    // Key held through reset release gives no event.
    repeat (4) step(16'h0004, 1'b1, 1'b0);
    check("held_at_reset", 16'(valid), 16'd0);
    repeat (2) step(16'h0000, 1'b1, 1'b0);

    // Single press: code 5 two cycles later, release is silent.
    step(16'h0020, 1'b1, 1'b0);
    check("single_latency1", 16'(valid), 16'd0);
    step(16'h0020, 1'b1, 1'b0);
    check("single_code", 16'(code), 16'd5);
    step(16'h0000, 1'b1, 1'b0);
    repeat (3) step(16'h0000, 1'b1, 1'b0);
    check("release_silent", 16'(valid), 16'd0);

    // Simultaneous presses come out in ascending order.
    step(16'h8101, 1'b1, 1'b0);
    step(16'h8101, 1'b1, 1'b0);
    check("simul_first", 16'(code), 16'd0);
    step(16'h8101, 1'b1, 1'b0);
    check("simul_second", 16'(code), 16'd8);
    step(16'h8101, 1'b1, 1'b0);
    check("simul_third", 16'(code), 16'd15);
    repeat (3) step(16'h0000, 1'b1, 1'b0);
    check("simul_no_ovf", 16'(overflow), 16'd0);

    // Backpressure: six presses with ready low, then drain.
    foreach (six[i]) begin
      step(16'(1) << six[i], 1'b0, 1'b0);
      step(16'h0000, 1'b0, 1'b0);
    end
    repeat (2) step(16'h0000, 1'b0, 1'b0);
    check("bp_head_held", 16'(code), 16'd1);
    repeat (10) step(16'h0000, 1'b1, 1'b0);
    check("bp_no_ovf", 16'(overflow), 16'd0);

    // Merge: fill the FIFO, then press key 3 twice while it is pending.
    for (int i = 2; i <= 8; i += 2) begin
      step(16'(1) << i, 1'b0, 1'b0);
      step(16'h0000, 1'b0, 1'b0);
    end
    step(16'h0008, 1'b0, 1'b0);
    step(16'h0000, 1'b0, 1'b0);
    step(16'h0008, 1'b0, 1'b0);
    check("merge_set", 16'(overflow), 16'd1);
    step(16'h0000, 1'b0, 1'b0);
    step(16'h0000, 1'b0, 1'b1);
    check("merge_clear", 16'(overflow), 16'd0);
    step(16'h0008, 1'b0, 1'b1);
    check("merge_set_wins", 16'(overflow), 16'd1);
    repeat (10) step(16'h0000, 1'b1, 1'b0);

    // Reset mid-operation drops queued events at once.
    for (int i = 10; i <= 12; i++) begin
      step(16'(1) << i, 1'b0, 1'b0);
      step(16'h0000, 1'b0, 1'b0);
    end
    step(16'h0000, 1'b0, 1'b0);
    Reset = 1'b0;
    #1;
    check("async_rst_valid", 16'(valid), 16'd0);
    check("async_rst_code", 16'(code), 16'd0);
    model_reset();
    compare_outputs();
    step(16'h0000, 1'b0, 1'b0);
    Reset = 1'b1;
    repeat (3) step(16'h0000, 1'b1, 1'b0);

    // Random traffic.
    k = '0;
    for (int n = 0; n < 800; n++) begin
      sel = $urandom_range(0, 9);
      if (sel >= 6 && sel <= 8) k = k ^ (16'(1) << $urandom_range(0, 15));
      else if (sel == 9)        k = 16'($urandom & $urandom & $urandom);
      step(k, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
